// File: rtl/serial_bus_master_if.sv
// Byte-stream and register-bus signals shared by serial_bus_master and its neighbours.
// The master modport is the command responder; the slave modport is the UART/bus side.
interface serial_bus_master_if;
    logic [7:0]  rx_data_i;
    logic        rx_strb_i;
    logic [7:0]  tx_data_o;
    logic        tx_strb_o;
    logic        tx_busy_i;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [15:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;

    modport master (
        input  rx_data_i, rx_strb_i, tx_busy_i, wb_dat_i, wb_ack_i,
        output tx_data_o, tx_strb_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
    );

    modport slave (
        output rx_data_i, rx_strb_i, tx_busy_i, wb_dat_i, wb_ack_i,
        input  tx_data_o, tx_strb_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
    );
endinterface

// File: rtl/serial_bus_master.sv
// Serial command responder: decodes fixed-length UART frames into single 16-bit
// register-bus reads/writes and returns a status (plus read data) response.
module serial_bus_master #(
    parameter int BUS_TIMEOUT = 1024,
    parameter int RX_TIMEOUT  = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_bus_master_if.master  bus,
    output logic                 frame_err_o
);

    localparam int RX_CW  = $clog2(RX_TIMEOUT + 1);
    localparam int BUS_CW = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [RX_CW-1:0]  RX_LIMIT  = RX_CW'(RX_TIMEOUT);
    localparam logic [BUS_CW-1:0] BUS_LIMIT = BUS_CW'(BUS_TIMEOUT - 1);

    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;
    localparam logic [7:0] STS_OK    = 8'h00;
    localparam logic [7:0] STS_TMO   = 8'hFF;
    localparam logic [7:0] STS_BADCM = 8'hFE;

    typedef enum logic [3:0] {
        ST_CMD     = 4'd0,
        ST_ADRH    = 4'd1,
        ST_ADRL    = 4'd2,
        ST_DATH    = 4'd3,
        ST_DATL    = 4'd4,
        ST_BUS     = 4'd5,
        ST_TX_WAIT = 4'd6,
        ST_TX_STRB = 4'd7,
        ST_TX_HOLD = 4'd8
    } state_t;

    function automatic logic [7:0] resp_byte(input logic [1:0]  idx,
                                             input logic [7:0]  status,
                                             input logic [15:0] data);
        logic [7:0] b;
        case (idx)
            2'd0:    b = status;
            2'd1:    b = data[15:8];
            2'd2:    b = data[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t            state_q, state_d;
    logic              rx_strb_q;
    logic              cmd_we_q, cmd_we_d;
    logic [15:0]       adr_q, adr_d;
    logic [15:0]       wdat_q, wdat_d;
    logic [15:0]       rdat_q, rdat_d;
    logic [7:0]        status_q, status_d;
    logic [1:0]        tx_idx_q, tx_idx_d;
    logic [1:0]        tx_last_q, tx_last_d;
    logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d;
    logic [BUS_CW-1:0] bus_cnt_q, bus_cnt_d;
    logic              wb_cyc_q, wb_cyc_d;
    logic              wb_stb_q, wb_stb_d;
    logic              wb_we_q, wb_we_d;
    logic [15:0]       wb_adr_q, wb_adr_d;
    logic [15:0]       wb_dat_q, wb_dat_d;
    logic              tx_strb_q, tx_strb_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              frame_err_q, frame_err_d;
    logic              byte_s;
    logic              start_bus_s;

    assign byte_s = bus.rx_strb_i & ~rx_strb_q;

    assign bus.wb_cyc_o  = wb_cyc_q;
    assign bus.wb_stb_o  = wb_stb_q;
    assign bus.wb_we_o   = wb_we_q;
    assign bus.wb_adr_o  = wb_adr_q;
    assign bus.wb_dat_o  = wb_dat_q;
    assign bus.tx_strb_o = tx_strb_q;
    assign bus.tx_data_o = tx_data_q;
    assign frame_err_o   = frame_err_q;

    // Edge detector keeps following the strobe level even through reset, so a
    // level that straddles reset is not seen as a second byte.
    always_ff @(posedge clk) begin
        rx_strb_q <= bus.rx_strb_i;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CMD;
            cmd_we_q    <= 1'b0;
            adr_q       <= 16'h0000;
            wdat_q      <= 16'h0000;
            rdat_q      <= 16'h0000;
            status_q    <= 8'h00;
            tx_idx_q    <= 2'd0;
            tx_last_q   <= 2'd0;
            rx_cnt_q    <= '0;
            bus_cnt_q   <= '0;
            wb_cyc_q    <= 1'b0;
            wb_stb_q    <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_adr_q    <= 16'h0000;
            wb_dat_q    <= 16'h0000;
            tx_strb_q   <= 1'b0;
            tx_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_we_q    <= cmd_we_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            rdat_q      <= rdat_d;
            status_q    <= status_d;
            tx_idx_q    <= tx_idx_d;
            tx_last_q   <= tx_last_d;
            rx_cnt_q    <= rx_cnt_d;
            bus_cnt_q   <= bus_cnt_d;
            wb_cyc_q    <= wb_cyc_d;
            wb_stb_q    <= wb_stb_d;
            wb_we_q     <= wb_we_d;
            wb_adr_q    <= wb_adr_d;
            wb_dat_q    <= wb_dat_d;
            tx_strb_q   <= tx_strb_d;
            tx_data_q   <= tx_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        cmd_we_d    = cmd_we_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        rdat_d      = rdat_q;
        status_d    = status_q;
        tx_idx_d    = tx_idx_q;
        tx_last_d   = tx_last_q;
        rx_cnt_d    = rx_cnt_q;
        bus_cnt_d   = bus_cnt_q;
        wb_cyc_d    = wb_cyc_q;
        wb_stb_d    = wb_stb_q;
        wb_we_d     = wb_we_q;
        wb_adr_d    = wb_adr_q;
        wb_dat_d    = wb_dat_q;
        tx_strb_d   = tx_strb_q;
        tx_data_d   = tx_data_q;
        frame_err_d = 1'b0;
        start_bus_s = 1'b0;

        case (state_q)
            ST_CMD: begin
                rx_cnt_d = '0;
                if (byte_s) begin
                    if ((bus.rx_data_i == CMD_WR) || (bus.rx_data_i == CMD_RD)) begin
                        cmd_we_d = (bus.rx_data_i == CMD_WR);
                        state_d  = ST_ADRH;
                    end else begin
                        frame_err_d = 1'b1;
                        status_d    = STS_BADCM;
                        tx_idx_d    = 2'd0;
                        tx_last_d   = 2'd0;
                        state_d     = ST_TX_WAIT;
                    end
                end else begin
                    state_d = ST_CMD;
                end
            end

            ST_ADRH, ST_ADRL, ST_DATH, ST_DATL: begin
                if (byte_s) begin
                    rx_cnt_d = '0;
                    case (state_q)
                        ST_ADRH: begin
                            adr_d[15:8] = bus.rx_data_i;
                            state_d     = ST_ADRL;
                        end
                        ST_ADRL: begin
                            adr_d[7:0] = bus.rx_data_i;
                            if (cmd_we_q) begin
                                state_d = ST_DATH;
                            end else begin
                                start_bus_s = 1'b1;
                            end
                        end
                        ST_DATH: begin
                            wdat_d[15:8] = bus.rx_data_i;
                            state_d      = ST_DATL;
                        end
                        ST_DATL: begin
                            wdat_d[7:0] = bus.rx_data_i;
                            start_bus_s = 1'b1;
                        end
                        default: state_d = ST_CMD;
                    endcase
                end else if (rx_cnt_q == RX_LIMIT) begin
                    // Stalled frame: discard silently, no response byte.
                    frame_err_d = 1'b1;
                    rx_cnt_d    = '0;
                    state_d     = ST_CMD;
                end else begin
                    rx_cnt_d = rx_cnt_q + RX_CW'(1);
                end
            end

            ST_BUS: begin
                if (bus.wb_ack_i) begin
                    wb_cyc_d  = 1'b0;
                    wb_stb_d  = 1'b0;
                    wb_we_d   = 1'b0;
                    rdat_d    = bus.wb_dat_i;
                    status_d  = STS_OK;
                    tx_idx_d  = 2'd0;
                    tx_last_d = cmd_we_q ? 2'd0 : 2'd2;
                    state_d   = ST_TX_WAIT;
                end else if (bus_cnt_q == BUS_LIMIT) begin
                    wb_cyc_d  = 1'b0;
                    wb_stb_d  = 1'b0;
                    wb_we_d   = 1'b0;
                    rdat_d    = 16'h0000;
                    status_d  = STS_TMO;
                    tx_idx_d  = 2'd0;
                    tx_last_d = cmd_we_q ? 2'd0 : 2'd2;
                    state_d   = ST_TX_WAIT;
                end else begin
                    bus_cnt_d = bus_cnt_q + BUS_CW'(1);
                end
            end

            ST_TX_WAIT: begin
                if (!bus.tx_busy_i) begin
                    tx_data_d = resp_byte(tx_idx_q, status_q, rdat_q);
                    tx_strb_d = 1'b1;
                    state_d   = ST_TX_STRB;
                end else begin
                    state_d = ST_TX_WAIT;
                end
            end

            ST_TX_STRB: begin
                if (bus.tx_busy_i) begin
                    tx_strb_d = 1'b0;
                    state_d   = ST_TX_HOLD;
                end else begin
                    tx_strb_d = 1'b1;
                end
            end

            ST_TX_HOLD: begin
                if (!bus.tx_busy_i) begin
                    if (tx_idx_q == tx_last_q) begin
                        state_d = ST_CMD;
                    end else begin
                        tx_idx_d = tx_idx_q + 2'd1;
                        state_d  = ST_TX_WAIT;
                    end
                end else begin
                    state_d = ST_TX_HOLD;
                end
            end

            default: begin
                state_d = ST_CMD;
            end
        endcase

        // Bus launch uses the just-shifted address/data so the final byte is included.
        if (start_bus_s) begin
            wb_cyc_d  = 1'b1;
            wb_stb_d  = 1'b1;
            wb_we_d   = cmd_we_q;
            wb_adr_d  = adr_d;
            wb_dat_d  = wdat_d;
            bus_cnt_d = '0;
            state_d   = ST_BUS;
        end else begin
            wb_adr_d = wb_adr_d;
        end
    end

endmodule

// File: tb/tb_serial_bus_master.sv
// Directed bench for serial_bus_master: frame-level model of expected bus accesses and
// response bytes, checked cycle by cycle against the DUT with small UART/slave models.
module tb_serial_bus_master;
    localparam int BUS_TO = 16;
    localparam int RX_TO  = 100;

    logic clk = 1'b0;
    logic reset;
    logic frame_err;

    serial_bus_master_if bif();

    serial_bus_master #(.BUS_TIMEOUT(BUS_TO), .RX_TIMEOUT(RX_TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bif),
        .frame_err_o (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [15:0] dat;
        int          stb_cycles;
    } acc_t;

    acc_t       exp_acc[$];
    logic [7:0] exp_tx[$];
    logic [7:0] tx_log[$];
    int         exp_err  = 0;
    int         err_seen = 0;
    int         errors   = 0;
    int         checks   = 0;

    int          ack_delay  = 0;
    logic [15:0] slave_data = 16'h0000;
    logic        late_ack   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: what a frame must produce on the bus and on the transmit side.
    task automatic expect_frame(input logic [7:0] cmd, input logic [15:0] adr, input logic [15:0] dat);
        acc_t a;
        a.adr        = adr;
        a.dat        = dat;
        a.stb_cycles = (ack_delay < 0) ? BUS_TO : ack_delay + 1;
        if (cmd == 8'h01) begin
            a.we = 1'b1;
            exp_acc.push_back(a);
            exp_tx.push_back((ack_delay < 0) ? 8'hFF : 8'h00);
        end else if (cmd == 8'h02) begin
            a.we = 1'b0;
            exp_acc.push_back(a);
            if (ack_delay < 0) begin
                exp_tx.push_back(8'hFF); exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
            end else begin
                exp_tx.push_back(8'h00);
                exp_tx.push_back(slave_data[15:8]);
                exp_tx.push_back(slave_data[7:0]);
            end
        end else begin
            exp_err++;
            exp_tx.push_back(8'hFE);
        end
    endtask

    // Bus slave: acks the ack_delay-th strobe cycle, data valid only with ack.
    initial begin
        int cnt = 0;
        bif.wb_ack_i = 1'b0;
        bif.wb_dat_i = 16'h0000;
        forever begin
            @(posedge clk); #1;
            if (bif.wb_stb_o) begin
                bif.wb_ack_i = (ack_delay >= 0) && (cnt == ack_delay);
                cnt++;
            end else begin
                cnt = 0;
                bif.wb_ack_i = late_ack;
            end
            bif.wb_dat_i = bif.wb_ack_i ? slave_data : 16'hDEAD;
        end
    end

    // UART transmitter: accepts a strobe after 2 cycles, then stays busy for 5.
    initial begin
        int acc  = 0;
        int bcnt = 0;
        bif.tx_busy_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bif.tx_busy_i) begin
                bcnt--;
                if (bcnt == 0) bif.tx_busy_i = 1'b0;
            end else if (bif.tx_strb_o) begin
                acc++;
                if (acc == 2) begin
                    bif.tx_busy_i = 1'b1;
                    bcnt = 5;
                    acc  = 0;
                    tx_log.push_back(bif.tx_data_o);
                end
            end else begin
                acc = 0;
            end
        end
    end

    // Compare process: every cycle against the frame model.
    initial begin
        logic       prev_strb = 1'b0;
        logic       prev_busy = 1'b0;
        logic       prev_err  = 1'b0;
        logic       prev_cyc  = 1'b0;
        logic [7:0] prev_data = 8'h00;
        int         stb_cnt   = 0;
        forever begin
            @(negedge clk);
            if (frame_err) begin
                err_seen++;
                chk("frame_err_one_cycle", {31'd0, prev_err}, 32'd0);
            end
            if (bif.wb_cyc_o) begin
                if (!prev_cyc) chk("bus_pending", exp_acc.size(), 32'd1);
                stb_cnt++;
                if (exp_acc.size() > 0) begin
                    chk("wb_stb_eq_cyc", {31'd0, bif.wb_stb_o}, 32'd1);
                    chk("wb_we", {31'd0, bif.wb_we_o}, {31'd0, exp_acc[0].we});
                    chk("wb_adr", {16'd0, bif.wb_adr_o}, {16'd0, exp_acc[0].adr});
                    if (exp_acc[0].we) chk("wb_dat", {16'd0, bif.wb_dat_o}, {16'd0, exp_acc[0].dat});
                end
            end else if (prev_cyc) begin
                chk("wb_stb_drop", {31'd0, bif.wb_stb_o}, 32'd0);
                if (exp_acc.size() > 0) begin
                    if (exp_acc[0].stb_cycles >= 0)
                        chk("stb_cycles", stb_cnt, exp_acc[0].stb_cycles);
                    void'(exp_acc.pop_front());
                end
                stb_cnt = 0;
            end else begin
                stb_cnt = 0;
            end
            if (bif.tx_strb_o && !prev_strb) begin
                chk("strb_rise_busy_low", {31'd0, bif.tx_busy_i}, 32'd0);
                chk("tx_pending", {31'd0, exp_tx.size() > 0}, 32'd1);
                if (exp_tx.size() > 0) chk("tx_byte", {24'd0, bif.tx_data_o}, {24'd0, exp_tx.pop_front()});
            end
            if (bif.tx_strb_o && prev_strb) chk("tx_data_stable", {24'd0, bif.tx_data_o}, {24'd0, prev_data});
            if (!bif.tx_strb_o && prev_strb) chk("strb_held_until_busy", {31'd0, prev_busy}, 32'd1);
            prev_strb = bif.tx_strb_o;
            prev_busy = bif.tx_busy_i;
            prev_err  = frame_err;
            prev_cyc  = bif.wb_cyc_o;
            prev_data = bif.tx_data_o;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bif.rx_data_i = b;
        bif.rx_strb_i = 1'b1;
        repeat (5) @(posedge clk);
        #1 bif.rx_strb_i = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_tx.size() == 0 && exp_acc.size() == 0 && !bif.tx_busy_i &&
                !bif.tx_strb_o && !bif.wb_cyc_o) break;
        end
        repeat (4) @(negedge clk);
        chk("resp_pending", exp_tx.size(), 32'd0);
        chk("bus_left_pending", exp_acc.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cyc"},   {31'd0, bif.wb_cyc_o},  32'd0);
        chk({tag, "_stb"},   {31'd0, bif.wb_stb_o},  32'd0);
        chk({tag, "_we"},    {31'd0, bif.wb_we_o},   32'd0);
        chk({tag, "_adr"},   {16'd0, bif.wb_adr_o},  32'd0);
        chk({tag, "_dat"},   {16'd0, bif.wb_dat_o},  32'd0);
        chk({tag, "_txstb"}, {31'd0, bif.tx_strb_o}, 32'd0);
        chk({tag, "_txdat"}, {24'd0, bif.tx_data_o}, 32'd0);
        chk({tag, "_ferr"},  {31'd0, frame_err},     32'd0);
    endtask

    initial begin
        int n;
        acc_t a;
        reset = 1'b1;
        bif.rx_data_i = 8'h00;
        bif.rx_strb_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 reset = 1'b0;

        // Write with ack after 3 cycles.
        ack_delay = 3;
        expect_frame(8'h01, 16'h1234, 16'hBEEF);
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'hBE); send_byte(8'hEF);
        wait_idle();
        chk("t1_log_len", tx_log.size(), 32'd1);
        chk("t1_status", {24'd0, tx_log[0]}, 32'h00);

        // Read acked in first strobe cycle.
        ack_delay = 0; slave_data = 16'hA55A;
        expect_frame(8'h02, 16'h0010, 16'h0000);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h10);
        wait_idle();
        chk("t2_log_len", tx_log.size(), 32'd4);
        chk("t2_b0", {24'd0, tx_log[1]}, 32'h00);
        chk("t2_b1", {24'd0, tx_log[2]}, 32'hA5);
        chk("t2_b2", {24'd0, tx_log[3]}, 32'h5A);

        // Read with no ack: bus timeout, then a late ack.
        ack_delay = -1;
        expect_frame(8'h02, 16'h0020, 16'h0000);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h20);
        wait_idle();
        late_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1 late_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_log_len", tx_log.size(), 32'd7);
        chk("t3_b0", {24'd0, tx_log[4]}, 32'hFF);
        chk("t3_b1", {24'd0, tx_log[5]}, 32'h00);
        chk("t3_b2", {24'd0, tx_log[6]}, 32'h00);

        // Invalid command, then a normal write.
        ack_delay = 2;
        expect_frame(8'h7E, 16'h0000, 16'h0000);
        send_byte(8'h7E);
        wait_idle();
        chk("t4_err_count", err_seen, exp_err);
        chk("t4_err_literal", err_seen, 32'd1);
        chk("t4_resp", {24'd0, tx_log[tx_log.size() - 1]}, 32'hFE);
        expect_frame(8'h01, 16'hABCD, 16'h1234);
        send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h12); send_byte(8'h34);
        wait_idle();

        // Stalled frame: inter-byte timeout.
        n = tx_log.size();
        send_byte(8'h01); send_byte(8'h00);
        exp_err++;
        repeat (150) @(posedge clk);
        @(negedge clk);
        chk("t5_err_count", err_seen, exp_err);
        chk("t5_no_resp", tx_log.size(), n);
        ack_delay = 1; slave_data = 16'h1357;
        expect_frame(8'h02, 16'h0001, 16'h0000);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
        wait_idle();
        chk("t5_b1", {24'd0, tx_log[tx_log.size() - 2]}, 32'h13);
        chk("t5_b2", {24'd0, tx_log[tx_log.size() - 1]}, 32'h57);

        // Reset in the middle of a read access.
        n = tx_log.size();
        ack_delay = -1;
        a.we = 1'b0; a.adr = 16'h0030; a.dat = 16'h0000; a.stb_cycles = -1;
        exp_acc.push_back(a);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h30);
        for (int i = 0; i < 20; i++) begin
            if (bif.wb_cyc_o) break;
            @(negedge clk);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1 reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("t6_no_resp", tx_log.size(), n);
        chk("t6_acc_cleared", exp_acc.size(), 32'd0);
        ack_delay = 0;
        expect_frame(8'h01, 16'h55AA, 16'h0001);
        send_byte(8'h01); send_byte(8'h55); send_byte(8'hAA); send_byte(8'h00); send_byte(8'h01);
        wait_idle();
        chk("t6_resp", {24'd0, tx_log[tx_log.size() - 1]}, 32'h00);
        chk("final_err_count", err_seen, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_bus_master.md
Name: serial_bus_master

Overview:
- Command responder on the byte side of serial_uart: takes received bytes from as_data_o/as_dstrb_o and drives transmit bytes into as_data_i/as_dstrb_i/as_busy_o.
- Decodes fixed-length command frames into single 16-bit Wishbone-style bus reads and writes, then returns a status/data response through the UART.
- Gives the monitor host-side serial access to the internal register bus.

Parameters:
- BUS_TIMEOUT, 1024, cycles wb_stb_o may stay high without wb_ack_i before the access is aborted.
- RX_TIMEOUT, 65535, idle cycles allowed between bytes of one frame before the frame is discarded.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data_i  in  8  received byte (connects to UART as_data_o)
- rx_strb_i  in  1  byte-valid level from UART (as_dstrb_o); a new byte is signalled by its rising edge
- tx_data_o  out  8  byte to transmit (to UART as_data_i)
- tx_strb_o  out  1  transmit request (to UART as_dstrb_i)
- tx_busy_i  in  1  UART transmitter busy (as_busy_o)
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  bus strobe
- wb_we_o  out  1  1 = write
- wb_adr_o  out  16  bus address
- wb_dat_o  out  16  write data
- wb_dat_i  in  16  read data
- wb_ack_i  in  1  bus acknowledge
- frame_err_o  out  1  one-cycle pulse on a discarded or invalid frame

Behaviour:
- Reset (synchronous, active-high, clocked on clk) sets all outputs to 0, the FSM to CMD, and all counters to 0.
- Reset mid-bus-access drops wb_cyc_o/wb_stb_o on the next edge. Reset mid-transmit drops tx_strb_o on the next edge.
- Byte capture: rx_strb_q is registered. A byte is taken when rx_strb_i & ~rx_strb_q. A level held over many cycles counts as one byte.
- Frame format:
  - Byte 0 is the command: 0x01 = write, 0x02 = read.
  - Bytes 1–2: address, high byte then low byte.
  - Write only, bytes 3–4: data, high byte then low byte.
- FSM states: CMD, ADRH, ADRL, DATH, DATL, BUS, TX_WAIT, TX_STRB, TX_HOLD.
- CMD:
  - On 0x01 or 0x02, latch the command and go to ADRH.
  - Any other byte pulses frame_err_o, queues a 1-byte response 0xFE, and goes to TX_WAIT.
- ADRH / ADRL / DATH / DATL: shift each byte into the address or data register.
  - A read goes from ADRL to BUS.
  - A write goes ADRL → DATH → DATL → BUS.
- Inter-byte timeout:
  - A counter runs in ADRH..DATL and clears on every captured byte.
  - When it reaches RX_TIMEOUT: pulse frame_err_o, return to CMD, send no response.
- BUS:
  - On the entry edge, set wb_cyc_o = wb_stb_o = 1, wb_we_o from the command, and drive wb_adr_o/wb_dat_o from the latched registers.
  - Hold until wb_ack_i is sampled high. Ack in the first cycle is legal.
  - On the next edge, cyc/stb go to 0 and wb_dat_i is captured on the ack cycle.
  - Status becomes 0x00.
- Bus timeout:
  - If wb_stb_o has been high for BUS_TIMEOUT cycles with no ack, drop cyc/stb.
  - Status becomes 0xFF and read data becomes 0x0000.
  - A late ack after this is ignored.
- Responses:
  - Write: 1 byte, the status.
  - Read: 3 bytes, status, data[15:8], data[7:0].
  - A 2-bit index selects the byte on tx_data_o.
- Transmit handshake, per byte:
  - TX_WAIT: wait for tx_busy_i == 0.
  - TX_STRB: hold tx_strb_o = 1 with tx_data_o stable until tx_busy_i == 1.
  - TX_HOLD: tx_strb_o = 0; wait for tx_busy_i == 0.
  - Then send the next byte, or return to CMD after the last one.
- Bytes arriving in BUS or TX_* states are dropped and not queued. The edge detector keeps tracking, so no stale edge is seen on return to CMD.
- wb_adr_o/wb_dat_o hold their values outside bus cycles. wb_we_o is meaningful only while wb_cyc_o is high.

Test Plan:
- Write frame 01 12 34 BE EF, ack 3 cycles after stb → exactly one bus cycle with we=1, adr 0x1234, dat 0xBEEF; response byte 0x00.
- Read frame 02 00 10, slave returns 0xA55A with ack in the first stb cycle → stb high exactly 1 cycle; response 00 A5 5A in order, each strobe held until busy rises.
- Read 02 00 20, no ack, BUS_TIMEOUT=16 → stb drops after 16 cycles; response FF 00 00; ack asserted later has no effect.
- Invalid command 0x7E → frame_err_o pulse; response 0xFE; a following valid write completes normally.
- Send 01 00, then idle beyond RX_TIMEOUT=100 → frame_err_o pulse, no response, no bus cycle; next frame 02 00 01 decodes correctly.
- Loopback through serial_uart with an rx_strb_i level held 5 cycles per byte, and reset asserted mid-read → no duplicate bytes; after reset, outputs are 0 and the next frame works.
